uart_rx: RTL and testbench

UART receive stage: the counterpart of the transmitter on the serial link. It deserialises 8N1 frames (1 start, 8 data LSB-first, 1 stop) from the asynchronous rx line. Each byte is presented to the downstream consumer through a valid/ready handshake. The block reports framing errors and overruns as single-cycle pulses.

---
 rtl/uart_rx_if.sv | 9 +
 rtl/uart_rx.sv | 119 +++++++++++
 tb/tb_uart_rx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Byte handshake between the UART receiver and its downstream consumer.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input  rx_ready);
  modport slave  (input  rx_data, input  rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx_in, samples mid-bit and hands each byte
// to the consumer over a valid/ready handshake with framing/overrun pulses.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line idle, waiting for a falling edge on the synchronised rx
// ST_START | half a bit into the start bit to confirm it is still low
// ST_DATA  | sampling 8 data bits LSB first, one per bit period
// ST_STOP  | sampling the stop bit, then completing or discarding the byte
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_in,
  uart_rx_if.master   rx_bus,
  output logic        rx_busy,
  output logic        framing_error,
  output logic        rx_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_s_d;
  logic [CW-1:0]          cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shift_q;
  logic [7:0]             data_q;
  logic                   valid_q;

  assign rx_s            = sync_q[SYNC_STAGES-1];
  assign rx_busy         = (state != ST_IDLE);
  assign rx_bus.rx_data  = data_q;
  assign rx_bus.rx_valid = valid_q;

  // Flops reset to the idle-high line level so reset release is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      rx_s_d <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
      rx_s_d <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      framing_error <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      rx_overrun    <= 1'b0;
      if (valid_q && rx_bus.rx_ready)
        valid_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (rx_s_d && !rx_s)
            state <= ST_START;
        end
        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt              <= '0;
            shift_q[bit_idx] <= rx_s;
            bit_idx          <= bit_idx + 3'd1;
            if (bit_idx == 3'd7)
              state <= ST_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
            if (!rx_s) begin
              framing_error <= 1'b1;
            end else if (!valid_q || rx_bus.rx_ready) begin
              // Overrides the accept-clear above when a byte is swapped in.
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              rx_overrun <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: scoreboard of sent bytes, pulse counters from a
// negedge monitor, immediate-assertion checks.
module tb_uart_rx;
  localparam int CPB  = 16;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_in = 1'b1;
  logic rx_busy, framing_error, rx_overrun;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_in         (rx_in),
    .rx_bus        (bus),
    .rx_busy       (rx_busy),
    .framing_error (framing_error),
    .rx_overrun    (rx_overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int busy_cnt = 0;
  int popped = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A handshake completes on the next posedge whenever valid & ready here.
  always @(negedge clk) begin
    if (framing_error) fe_cnt++;
    if (rx_overrun)    ov_cnt++;
    if (rx_busy)       busy_cnt++;
    if (!reset && bus.rx_valid && bus.rx_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", {24'd0, bus.rx_data}, 32'hFFFF_FFFF);
      end else begin
        chk("rx_byte", {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
        popped++;
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    wait_cycles(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
  endtask

  task automatic accept_pulse();
    bus.rx_ready = 1'b1;
    wait_cycles(1);
    bus.rx_ready = 1'b0;
  endtask

  int fe_base, ov_base, pop_base;

  initial begin
    bus.rx_ready = 1'b0;
    wait_cycles(3);
    chk("rst_valid", {31'd0, bus.rx_valid}, 32'd0);
    chk("rst_data",  {24'd0, bus.rx_data},  32'd0);
    chk("rst_busy",  {31'd0, rx_busy},      32'd0);
    chk("rst_fe",    {31'd0, framing_error}, 32'd0);
    chk("rst_ov",    {31'd0, rx_overrun},   32'd0);
    reset = 1'b0;
    wait_cycles(20);

    // Single byte held until accepted.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_cycles(4);
    chk("a5_valid", {31'd0, bus.rx_valid}, 32'd1);
    chk("a5_data",  {24'd0, bus.rx_data},  32'hA5);
    wait_cycles(20);
    chk("a5_held",  {31'd0, bus.rx_valid}, 32'd1);
    accept_pulse();
    chk("a5_clear", {31'd0, bus.rx_valid}, 32'd0);
    chk("a5_pop",   popped, 32'd1);
    chk("a5_fe",    fe_cnt, 32'd0);

    // False start.
    wait_cycles(10);
    busy_cnt = 0;
    rx_in = 1'b0;
    wait_cycles(4);
    rx_in = 1'b1;
    wait_cycles(40);
    chk("fs_busy_seen", {31'd0, (busy_cnt > 0)}, 32'd1);
    chk("fs_busy_len",  {31'd0, (busy_cnt <= 8 + SYNC)}, 32'd1);
    chk("fs_idle",      {31'd0, rx_busy},      32'd0);
    chk("fs_valid",     {31'd0, bus.rx_valid}, 32'd0);

    // Framing error, then line held low (break).
    fe_base = fe_cnt;
    send_frame(8'h3C, 1'b0);
    wait_cycles(2);
    chk("fe_pulse", fe_cnt - fe_base, 32'd1);
    chk("fe_valid", {31'd0, bus.rx_valid}, 32'd0);
    busy_cnt = 0;
    wait_cycles(3 * CPB);
    chk("brk_busy", busy_cnt, 32'd0);
    chk("brk_fe",   fe_cnt - fe_base, 32'd1);
    rx_in = 1'b1;
    wait_cycles(2 * CPB);

    // Overrun: second byte dropped while first still held.
    ov_base  = ov_cnt;
    pop_base = popped;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_cycles(4);
    chk("ov_pulse", ov_cnt - ov_base, 32'd1);
    chk("ov_data",  {24'd0, bus.rx_data},  32'h11);
    chk("ov_valid", {31'd0, bus.rx_valid}, 32'd1);
    accept_pulse();
    chk("ov_pop",   popped - pop_base, 32'd1);

    // Back-to-back frames with ready tied high.
    wait_cycles(CPB);
    fe_base  = fe_cnt;
    ov_base  = ov_cnt;
    pop_base = popped;
    bus.rx_ready = 1'b1;
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1);
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    wait_cycles(24);
    bus.rx_ready = 1'b0;
    chk("b2b_pop", popped - pop_base, 32'd3);
    chk("b2b_fe",  fe_cnt - fe_base,  32'd0);
    chk("b2b_ov",  ov_cnt - ov_base,  32'd0);

    // Reset mid-DATA of 0x81 (bits 1,0,0 sent), then 0x42.
    fe_base = fe_cnt;
    ov_base = ov_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    reset = 1'b1;
    #1;
    chk("mr_valid", {31'd0, bus.rx_valid}, 32'd0);
    chk("mr_data",  {24'd0, bus.rx_data},  32'd0);
    chk("mr_busy",  {31'd0, rx_busy},      32'd0);
    rx_in = 1'b1;
    wait_cycles(5);
    chk("mr_fe",    {31'd0, framing_error}, 32'd0);
    chk("mr_ov",    {31'd0, rx_overrun},    32'd0);
    reset = 1'b0;
    wait_cycles(3 * CPB);
    chk("mr_idle",  {31'd0, rx_busy},      32'd0);
    chk("mr_novld", {31'd0, bus.rx_valid}, 32'd0);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    wait_cycles(4);
    chk("r42_valid", {31'd0, bus.rx_valid}, 32'd1);
    chk("r42_data",  {24'd0, bus.rx_data},  32'h42);
    accept_pulse();
    chk("r42_clear", {31'd0, bus.rx_valid}, 32'd0);
    chk("r42_fe",    fe_cnt - fe_base, 32'd0);
    chk("r42_ov",    ov_cnt - ov_base, 32'd0);

    wait_cycles(4);
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
